// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cmp_pkg.sv
// Shared definitions for the XNOR/XOR compare pipeline.
//  - MODE_XNOR / MODE_XOR : encodings of the per-beat MODE bit
//  - WIDTH_MAX, STAGES_MAX, CNT_W_MAX : legal upper bounds of the top-level parameters
//  - bitcmp() : bitwise XNOR or XOR of two operands at the maximum width;
//               callers zero-extend their operands and keep the low bits they need.
package gf180mcu_fd_sc_mcu7t5v0__cmp_pkg;

  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_XOR  = 1'b1;

  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MAX = 8;
  localparam int CNT_W_MAX  = 32;

  typedef enum logic {
    CMP_XNOR = MODE_XNOR,
    CMP_XOR  = MODE_XOR
  } cmp_mode_e;

  function automatic logic [WIDTH_MAX-1:0] bitcmp(input logic [WIDTH_MAX-1:0] a,
                                                   input logic [WIDTH_MAX-1:0] b,
                                                   input logic             mode);
    return (mode == MODE_XOR) ? (a ^ b) : ~(a ^ b);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe_if.sv
// Beat-level interface of the compare pipeline.
//  - A1, A2, MODE, IN_VALID / IN_READY : input beat and its handshake
//  - ZN, MATCH, OUT_VALID / OUT_READY  : output beat and its handshake
//  - CNT_CLR, MATCH_CNT                : match counter clear and value
// master = the side that produces input beats and consumes results; slave = the pipeline.
interface gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] A2;
  logic             MODE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] ZN;
  logic             MATCH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             CNT_CLR;
  logic [CNT_W-1:0] MATCH_CNT;

  modport master (
    output A1, A2, MODE, IN_VALID, OUT_READY, CNT_CLR,
    input  IN_READY, ZN, MATCH, OUT_VALID, MATCH_CNT
  );

  modport slave (
    input  A1, A2, MODE, IN_VALID, OUT_READY, CNT_CLR,
    output IN_READY, ZN, MATCH, OUT_VALID, MATCH_CNT
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cmp_pipe_stage.sv
// One pipeline slot: a {valid, data} register with its own load enable.
//  - clk, rst_n      : clock, asynchronous active-low reset
//  - down_load       : the slot downstream is loading (or, for the last slot, the output is ready)
//  - d_valid, d_data : beat offered by the upstream slot
//  - q_valid, q_data : registered contents
// A slot loads whenever it is empty or its contents move on, so bubbles collapse.
module gf180mcu_fd_sc_mcu7t5v0__cmp_pipe_stage
  import gf180mcu_fd_sc_mcu7t5v0__cmp_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         down_load,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         load;

  assign load = ~valid_reg | down_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= d_valid;
      // Data only moves with a real beat; a bubble leaves the old contents in place.
      if (d_valid) begin
        data_reg <= d_data;
      end
    end
  end

  assign q_valid = valid_reg;
  assign q_data  = data_reg;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe.sv
// Registered WIDTH-bit XNOR/XOR compare slice with equality flag, STAGES-deep
// valid/ready pipeline and a saturating count of matching output beats.
//  - CLK, RN  : clock (rising edge), asynchronous active-low reset
//  - VDD, VSS : supply pins, carried for netlist compatibility only
//  - bus      : beat interface (A1, A2, MODE, IN_VALID/IN_READY, ZN, MATCH,
//               OUT_VALID/OUT_READY, CNT_CLR, MATCH_CNT)
// The compare is evaluated combinationally into stage 0; each later stage just
// carries {match, zn}. Latency with no stall is STAGES edges from input accept.
module gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe
  import gf180mcu_fd_sc_mcu7t5v0__cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe_if.slave bus
);

  localparam int DW = WIDTH + 1;  // {match, zn}

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("WIDTH out of range 1..64");
  end
  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("STAGES out of range 1..8");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("CNT_W out of range 1..32");
  end

  // IN_READY stays low until the first edge after reset release.
  logic run_reg;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Stage-0 compare at full package width, then trimmed to WIDTH.
  logic [WIDTH_MAX-1:0] a1_ext;
  logic [WIDTH_MAX-1:0] a2_ext;
  logic [WIDTH_MAX-1:0] cmp_wide;
  logic [DW-1:0]        stage0_data;

  always_comb begin
    a1_ext              = '0;
    a2_ext              = '0;
    a1_ext[WIDTH-1:0]   = bus.A1;
    a2_ext[WIDTH-1:0]   = bus.A2;
  end

  assign cmp_wide    = bitcmp(a1_ext, a2_ext, bus.MODE);
  assign stage0_data = {(bus.A1 == bus.A2), cmp_wide[WIDTH-1:0]};

  // Ready chain. A stage loads when it is empty or the next stage loads, so
  // stage k may load iff OUT_READY or some stage at or behind... ahead of it
  // (index >= k) is empty. Walking from the output end keeps this free of
  // element-to-element combinational feedback.
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] down_load;
  logic [DW-1:0]     data_arr [STAGES];
  logic              head_load;
  logic              in_ready;

  always_comb begin : ready_chain
    logic acc;
    acc       = bus.OUT_READY;
    down_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      down_load[k] = acc;
      acc          = acc | ~valid_vec[k];
    end
    head_load = acc;
  end

  assign in_ready = head_load & run_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic          d_valid_w;
    logic [DW-1:0] d_data_w;

    if (gi == 0) begin : g_head
      assign d_valid_w = bus.IN_VALID & in_ready;
      assign d_data_w  = stage0_data;
    end else begin : g_body
      assign d_valid_w = valid_vec[gi-1];
      assign d_data_w  = data_arr[gi-1];
    end

    gf180mcu_fd_sc_mcu7t5v0__cmp_pipe_stage #(
      .W (DW)
    ) u_stage (
      .clk       (CLK),
      .rst_n     (RN),
      .down_load (down_load[gi]),
      .d_valid   (d_valid_w),
      .d_data    (d_data_w),
      .q_valid   (valid_vec[gi]),
      .q_data    (data_arr[gi])
    );
  end

  logic out_valid;
  logic out_match;
  logic out_acc;

  assign out_valid = valid_vec[STAGES-1];
  assign out_match = data_arr[STAGES-1][WIDTH];
  assign out_acc   = out_valid & bus.OUT_READY;

  // Saturating match counter; clear beats a coincident increment.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_reg <= '0;
    end else if (bus.CNT_CLR) begin
      cnt_reg <= '0;
    end else if (out_acc && out_match && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.ZN        = data_arr[STAGES-1][WIDTH-1:0];
  assign bus.MATCH     = out_match;
  assign bus.OUT_VALID = out_valid;
  assign bus.MATCH_CNT = cnt_reg;

  // Supply pins and the trimmed-off compare bits have no logical function.
  logic unused_sig;
  assign unused_sig = ^{VDD, VSS, cmp_wide};

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe.sv
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe;

  localparam int NI = 3;  // u0: STAGES=2 CNT_W=2, u1: STAGES=1 CNT_W=3, u2: STAGES=8 CNT_W=3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wire vdd;
  wire vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  logic [7:0] a1_d [NI];
  logic [7:0] a2_d [NI];
  logic       mode_d [NI];
  logic       iv_d [NI];
  logic       or_d [NI];
  logic       clr_d [NI];
  logic       rn_d [NI];

  wire        ir_o [NI];
  wire        ov_o [NI];
  wire        m_o [NI];
  wire [7:0]  zn_o [NI];
  wire [7:0]  cnt_o [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit drain_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int STG  = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
    localparam int CW   = (gi == 0) ? 2 : 3;
    localparam int CMAX = (1 << CW) - 1;

    gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe_if #(.WIDTH(8), .CNT_W(CW)) bus ();

    assign bus.A1        = a1_d[gi];
    assign bus.A2        = a2_d[gi];
    assign bus.MODE      = mode_d[gi];
    assign bus.IN_VALID  = iv_d[gi];
    assign bus.OUT_READY = or_d[gi];
    assign bus.CNT_CLR   = clr_d[gi];
    assign ir_o[gi]      = bus.IN_READY;
    assign ov_o[gi]      = bus.OUT_VALID;
    assign m_o[gi]       = bus.MATCH;
    assign zn_o[gi]      = bus.ZN;
    assign cnt_o[gi]     = 8'(bus.MATCH_CNT);

    gf180mcu_fd_sc_mcu7t5v0__xnor_cmp_pipe #(
      .WIDTH  (8),
      .STAGES (STG),
      .CNT_W  (CW)
    ) u_dut (
      .CLK (clk),
      .RN  (rn_d[gi]),
      .VDD (vdd),
      .VSS (vss),
      .bus (bus.slave)
    );

    // Reference: a FIFO of expected {match, zn} in acceptance order plus a
    // saturating counter; the pipe holds at most STG beats.
    logic [8:0] q[$];
    int         cnt_m = 0;
    bit         run_m = 1'b0;
    bit         stall_prev = 1'b0;
    bit         empty_done = 1'b0;
    logic [8:0] prev_out = '0;

    always @(negedge clk) begin
      string      p;
      logic [7:0] x;
      logic [7:0] zn_e;
      p = $sformatf("u%0d", gi);
      if (!rn_d[gi]) begin
        chk({p, " rst_zn"}, bus.ZN, 0);
        chk({p, " rst_match"}, bus.MATCH, 0);
        chk({p, " rst_out_valid"}, bus.OUT_VALID, 0);
        chk({p, " rst_cnt"}, bus.MATCH_CNT, 0);
        chk({p, " rst_in_ready"}, bus.IN_READY, 0);
        q.delete();
        cnt_m      = 0;
        run_m      = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (run_m) chk({p, " in_ready"}, bus.IN_READY, (q.size() < STG) || or_d[gi]);
        chk({p, " match_cnt"}, bus.MATCH_CNT, cnt_m);
        if (stall_prev) chk({p, " stall_hold"}, {bus.OUT_VALID, bus.MATCH, bus.ZN}, {1'b1, prev_out});
        if (bus.OUT_VALID) begin
          if (q.size() == 0) begin
            chk({p, " phantom_beat"}, bus.OUT_VALID, 0);
          end else begin
            chk({p, " zn"}, bus.ZN, q[0][7:0]);
            chk({p, " match"}, bus.MATCH, q[0][8]);
          end
        end
        // Apply what the next rising edge will do.
        stall_prev = bus.OUT_VALID && !or_d[gi];
        prev_out   = {bus.MATCH, bus.ZN};
        if (clr_d[gi]) cnt_m = 0;
        else if (bus.OUT_VALID && or_d[gi] && q.size() > 0 && q[0][8] && cnt_m < CMAX) cnt_m++;
        if (bus.OUT_VALID && or_d[gi] && q.size() > 0) void'(q.pop_front());
        if (iv_d[gi] && bus.IN_READY) begin
          x    = a1_d[gi] ^ a2_d[gi];
          zn_e = mode_d[gi] ? x : ~x;
          q.push_back({(a1_d[gi] == a2_d[gi]), zn_e});
        end
        run_m = 1'b1;
      end
      if (drain_req && !empty_done) begin
        chk({p, " drain_empty"}, q.size(), 0);
        empty_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat on u0 and hold it until accepted; returns 1ns after the accept edge.
  task automatic push0(input logic [7:0] a, input logic [7:0] b, input logic m);
    int guard;
    a1_d[0] = a; a2_d[0] = b; mode_d[0] = m; iv_d[0] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!ir_o[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("u0 push_timeout", ir_o[0], 1);
    @(posedge clk);
    #1;
    iv_d[0] = 1'b0;
  endtask

  // Single beat into an empty u0 with OUT_READY=1: checks latency and the result literally.
  task automatic one_beat(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [7:0] zn_e, input logic m_e, input string name);
    push0(a, b, m);
    @(negedge clk);
    chk({name, " early_valid"}, ov_o[0], 0);
    @(negedge clk);
    chk({name, " out_valid"}, ov_o[0], 1);
    chk({name, " zn"}, zn_o[0], zn_e);
    chk({name, " match"}, m_o[0], m_e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int outs;
    int cyc;
    int stale;
    for (int i = 0; i < NI; i++) begin
      a1_d[i] = '0; a2_d[i] = '0; mode_d[i] = 1'b0; iv_d[i] = 1'b0;
      or_d[i] = 1'b1; clr_d[i] = 1'b0; rn_d[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rn_d[i] = 1'b1;
    repeat (2) tick();

    // Literal results
    one_beat(8'hA5, 8'hA5, 1'b0, 8'hFF, 1'b1, "u0 xnor_eq");
    one_beat(8'hA5, 8'h5A, 1'b0, 8'h00, 1'b0, "u0 xnor_ne");
    one_beat(8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0, "u0 xor_ff");
    one_beat(8'h3C, 8'h0F, 1'b0, 8'hCC, 1'b0, "u0 xnor_cc");
    one_beat(8'h3C, 8'h0F, 1'b1, 8'h33, 1'b0, "u0 xor_33");

    // MODE alternating back-to-back
    push0(8'h81, 8'h18, 1'b0);
    push0(8'h81, 8'h18, 1'b1);
    @(negedge clk);
    chk("u0 alt_a valid", ov_o[0], 1);
    chk("u0 alt_a zn", zn_o[0], 8'h66);
    @(negedge clk);
    chk("u0 alt_b valid", ov_o[0], 1);
    chk("u0 alt_b zn", zn_o[0], 8'h99);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push0(8'($urandom), 8'($urandom), i[0]);
    repeat (4) tick();

    // Backpressure: 4 beats offered, OUT_READY low for 5 cycles
    or_d[0] = 1'b0;
    k = 0;
    a1_d[0] = 8'h40; a2_d[0] = 8'h40; mode_d[0] = 1'b0; iv_d[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ir_o[0]) k++;
      @(posedge clk);
      #1;
      a1_d[0] = 8'(8'h40 + k); a2_d[0] = a1_d[0];
    end
    chk("u0 bp_accepted", k, 2);
    chk("u0 bp_in_ready_low", ir_o[0], 0);
    or_d[0] = 1'b1;
    outs = 0;
    cyc  = 0;
    while (outs < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ov_o[0]) outs++;
      if (ir_o[0] && iv_d[0]) k++;
      @(posedge clk);
      #1;
      if (k < 4) begin
        a1_d[0] = 8'(8'h40 + k); a2_d[0] = a1_d[0];
      end else begin
        iv_d[0] = 1'b0;
      end
    end
    chk("u0 bp_drain_cycles", cyc, 4);
    repeat (2) tick();

    // Counter (CNT_W=2)
    clr_d[0] = 1'b1;
    tick();
    clr_d[0] = 1'b0;
    chk("u0 cnt_cleared", cnt_o[0], 0);
    for (int i = 0; i < 5; i++) push0(8'h5A, 8'h5A, i[0]);
    repeat (4) tick();
    chk("u0 cnt_sat", cnt_o[0], 3);
    push0(8'hC3, 8'hC3, 1'b0);
    tick();
    chk("u0 clr_align", ov_o[0], 1);
    clr_d[0] = 1'b1;
    tick();
    clr_d[0] = 1'b0;
    chk("u0 cnt_clr_wins", cnt_o[0], 0);
    push0(8'h99, 8'h99, 1'b1);
    repeat (3) tick();
    chk("u0 cnt_after_clr", cnt_o[0], 1);

    // Reset with two beats in flight
    or_d[0] = 1'b0;
    push0(8'h77, 8'h77, 1'b0);
    push0(8'h77, 8'h77, 1'b0);
    chk("u0 rst_pre_valid", ov_o[0], 1);
    rn_d[0] = 1'b0;
    #1;
    chk("u0 rst_now_zn", zn_o[0], 0);
    chk("u0 rst_now_match", m_o[0], 0);
    chk("u0 rst_now_valid", ov_o[0], 0);
    chk("u0 rst_now_cnt", cnt_o[0], 0);
    chk("u0 rst_now_in_ready", ir_o[0], 0);
    repeat (2) tick();
    rn_d[0] = 1'b1;
    or_d[0] = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov_o[0]) stale++;
    end
    chk("u0 rst_no_stale", stale, 0);
    @(posedge clk);
    #1;

    // Random soak on all instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        a1_d[i]   = 8'($urandom);
        a2_d[i]   = ($urandom_range(0, 1) == 0) ? a1_d[i] : 8'($urandom);
        mode_d[i] = 1'($urandom);
        iv_d[i]   = ($urandom_range(0, 9) < 7);
        or_d[i]   = ($urandom_range(0, 9) < ((c < 1500) ? 4 : 7));
        clr_d[i]  = ($urandom_range(0, 31) == 0);
      end
      tick();
    end

    for (int i = 0; i < NI; i++) begin
      iv_d[i] = 1'b0; or_d[i] = 1'b1; clr_d[i] = 1'b0;
    end
    repeat (20) tick();
    drain_req = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
